// File: rtl/bank_request_latency_tracker.sv
// Outstanding-request table for one memory bank: captures accepted requests,
// retires them on matching responses and emits a registered latency record.
module bank_request_latency_tracker #(
  parameter int DEPTH     = 8,
  parameter int RANK      = 0,
  parameter int BANKGROUP = 0,
  parameter int BANK      = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_fire,
  input  logic [31:0]                req_id,
  input  logic [31:0]                req_addr,
  input  logic                       req_is_write,
  input  logic                       resp_fire,
  input  logic [31:0]                resp_id,
  input  logic [63:0]                globalCycle,
  output logic                       track_ready,
  output logic [$clog2(DEPTH):0]     outstanding,
  output logic                       stat_valid,
  output logic [31:0]                stat_id,
  output logic [31:0]                stat_addr,
  output logic                       stat_is_write,
  output logic [31:0]                stat_latency,
  output logic [31:0]                max_latency,
  output logic [31:0]                completed,
  output logic                       err_overflow,
  output logic                       err_unmatched
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  if (DEPTH < 2 || DEPTH > 32 || (DEPTH & (DEPTH - 1)) != 0 ||
      RANK < 0 || BANKGROUP < 0 || BANK < 0) begin : g_bad_param
    $error("bank_request_latency_tracker: illegal parameter set");
  end

  // Handshake: req_fire and resp_fire are already-qualified transfer pulses
  // (the queue's valid && ready). track_ready is advisory; a req_fire seen
  // while it is low is dropped and recorded in err_overflow.

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] wr_q, wr_d;
  logic [31:0]      id_q    [DEPTH];
  logic [31:0]      id_d    [DEPTH];
  logic [31:0]      addr_q  [DEPTH];
  logic [31:0]      addr_d  [DEPTH];
  logic [63:0]      issue_q [DEPTH];
  logic [63:0]      issue_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;

  logic             stat_valid_q, stat_valid_d;
  logic [31:0]      stat_id_q, stat_id_d;
  logic [31:0]      stat_addr_q, stat_addr_d;
  logic             stat_wr_q, stat_wr_d;
  logic [31:0]      stat_lat_q, stat_lat_d;
  logic [31:0]      max_lat_q, max_lat_d;
  logic [31:0]      completed_q, completed_d;
  logic             err_ovf_q, err_ovf_d;
  logic             err_unm_q, err_unm_d;

  logic             free_found;
  logic [IW-1:0]    free_idx;
  logic             match_found;
  logic [IW-1:0]    match_idx;
  logic             alloc;
  logic             match;
  logic [63:0]      lat_full;
  logic [31:0]      lat_sat;

  assign track_ready = (count_q != CW'(DEPTH));

  // Both searches use start-of-cycle state, so a same-cycle request can never
  // satisfy this cycle's response and a freed slot is not reusable until next cycle.
  always_comb begin
    free_found  = 1'b0;
    free_idx    = '0;
    match_found = 1'b0;
    match_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
      if (valid_q[i] && (id_q[i] == resp_id)) begin
        match_found = 1'b1;
        match_idx   = IW'(i);
      end
    end
  end

  assign alloc = req_fire && track_ready && free_found;
  assign match = resp_fire && match_found;

  always_comb begin
    lat_full = globalCycle - issue_q[match_idx];
    lat_sat  = (|lat_full[63:32]) ? 32'hFFFF_FFFF : lat_full[31:0];
  end

  always_comb begin
    valid_d = valid_q;
    wr_d    = wr_q;
    for (int i = 0; i < DEPTH; i++) begin
      id_d[i]    = id_q[i];
      addr_d[i]  = addr_q[i];
      issue_d[i] = issue_q[i];
      if (alloc && (free_idx == IW'(i))) begin
        valid_d[i] = 1'b1;
        wr_d[i]    = req_is_write;
        id_d[i]    = req_id;
        addr_d[i]  = req_addr;
        issue_d[i] = globalCycle;
      end
      if (match && (match_idx == IW'(i))) begin
        valid_d[i] = 1'b0;
      end
    end
    count_d = count_q + CW'(alloc) - CW'(match);
  end

  always_comb begin
    stat_valid_d = match;
    stat_id_d    = stat_id_q;
    stat_addr_d  = stat_addr_q;
    stat_wr_d    = stat_wr_q;
    stat_lat_d   = stat_lat_q;
    max_lat_d    = max_lat_q;
    completed_d  = completed_q;
    if (match) begin
      stat_id_d   = id_q[match_idx];
      stat_addr_d = addr_q[match_idx];
      stat_wr_d   = wr_q[match_idx];
      stat_lat_d  = lat_sat;
      completed_d = completed_q + 32'd1;
      if (lat_sat > max_lat_q) begin
        max_lat_d = lat_sat;
      end
    end
    err_ovf_d = err_ovf_q | (req_fire & ~track_ready);
    err_unm_d = err_unm_q | (resp_fire & ~match_found);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q      <= '0;
      wr_q         <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        id_q[i]    <= '0;
        addr_q[i]  <= '0;
        issue_q[i] <= '0;
      end
      count_q      <= '0;
      stat_valid_q <= 1'b0;
      stat_id_q    <= '0;
      stat_addr_q  <= '0;
      stat_wr_q    <= 1'b0;
      stat_lat_q   <= '0;
      max_lat_q    <= '0;
      completed_q  <= '0;
      err_ovf_q    <= 1'b0;
      err_unm_q    <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      wr_q         <= wr_d;
      for (int i = 0; i < DEPTH; i++) begin
        id_q[i]    <= id_d[i];
        addr_q[i]  <= addr_d[i];
        issue_q[i] <= issue_d[i];
      end
      count_q      <= count_d;
      stat_valid_q <= stat_valid_d;
      stat_id_q    <= stat_id_d;
      stat_addr_q  <= stat_addr_d;
      stat_wr_q    <= stat_wr_d;
      stat_lat_q   <= stat_lat_d;
      max_lat_q    <= max_lat_d;
      completed_q  <= completed_d;
      err_ovf_q    <= err_ovf_d;
      err_unm_q    <= err_unm_d;
    end
  end

  assign outstanding   = count_q;
  assign stat_valid    = stat_valid_q;
  assign stat_id       = stat_id_q;
  assign stat_addr     = stat_addr_q;
  assign stat_is_write = stat_wr_q;
  assign stat_latency  = stat_lat_q;
  assign max_latency   = max_lat_q;
  assign completed     = completed_q;
  assign err_overflow  = err_ovf_q;
  assign err_unmatched = err_unm_q;

endmodule

// File: doc/bank_request_latency_tracker.md
Name: bank_request_latency_tracker

Overview:
Request-side counterpart to the per-bank response statistics logger. It captures each request accepted by a bank's physical memory (ID, address, type, issue cycle) in an outstanding-request table. On the matching response it retires the entry and emits a registered latency record. The block is synthesizable and sits beside each bank's request/response queue pair. Its outputs feed the statistics sinks and counters.

Parameters:
DEPTH, 8, outstanding-request table entries (power of 2, 2..32)
RANK, 0, rank index (carried for identification only)
BANKGROUP, 0, bank-group index (identification only)
BANK, 0, bank index (identification only)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
req_fire  in  1  request accepted this cycle
req_id  in  32  request ID
req_addr  in  32  request address
req_is_write  in  1  1 means write, 0 means read
resp_fire  in  1  response delivered this cycle
resp_id  in  32  response request ID
globalCycle  in  64  free-running cycle count
track_ready  out  1  table not full (combinational from registered count)
outstanding  out  $clog2(DEPTH)+1  number of valid entries
stat_valid  out  1  latency record valid (one-cycle pulse)
stat_id  out  32  retired request ID
stat_addr  out  32  retired address
stat_is_write  out  1  retired request type
stat_latency  out  32  response cycle minus issue cycle, saturated
max_latency  out  32  largest stat_latency since reset
completed  out  32  matched responses since reset, wraps
err_overflow  out  1  sticky: req_fire while full
err_unmatched  out  1  sticky: resp_fire with no matching valid entry

Behaviour:
- Reset (reset=0, asynchronous) clears all valid bits and sets every output to 0, except track_ready, which is 1. Internal sticky flags and counters also clear.
- Table entry fields: valid, id, addr, is_write, issue_cycle[63:0].
- Request allocation, when req_fire=1 and outstanding<DEPTH at the start of the cycle:
  - write into the lowest-index invalid entry;
  - issue_cycle = globalCycle sampled that cycle;
  - the entry is valid from the next cycle.
- Request while full: the request is dropped with no table change, and err_overflow is set. This holds even if a response frees a slot in the same cycle.
- Response lookup, when resp_fire=1:
  - resp_id is compared against all valid entries, using the table state at the start of the cycle;
  - if several match, the lowest index wins;
  - the winning entry is invalidated at the clock edge.
- Response record: the next cycle drives stat_valid=1 with the entry's id, addr and is_write.
  - stat_latency = globalCycle(at the resp cycle) - issue_cycle, computed at 64 bits.
  - If the difference exceeds 0xFFFFFFFF, stat_latency = 0xFFFFFFFF.
- Response with no match: err_unmatched is set, stat_valid stays 0, and the table is unchanged.
- Latency is therefore 1 cycle from resp_fire to stat_valid. stat_valid is 0 in any cycle not following a matched response.
- Simultaneous req_fire and resp_fire in the same cycle:
  - both are processed;
  - a request allocated this cycle cannot be matched by this cycle's resp_id, even when the IDs are equal;
  - a slot freed this cycle cannot be allocated this cycle.
- Next-state count: outstanding_next = outstanding + alloc - match, where alloc and match are each 0 or 1.
- Counters and flags:
  - max_latency updates in the same cycle as stat_valid: it becomes the maximum of its old value and stat_latency;
  - completed increments with each stat_valid and wraps from 0xFFFFFFFF to 0;
  - the sticky error flags clear only on reset.
- Duplicate outstanding IDs are legal. Each response retires exactly one entry.
- Assertion of reset mid-operation discards all entries immediately. A stat_valid pulse in flight is suppressed.

Test Plan:
- Single read: req id=5 addr=0x100 at globalCycle=10; resp id=5 at cycle 17 → at cycle 18: stat_valid=1, stat_id=5, stat_addr=0x100, stat_is_write=0, stat_latency=7, completed=1, max_latency=7.
- Fill and overflow: with DEPTH=8, issue 8 requests (ids 0..7) → track_ready=0, outstanding=8. A 9th req id=8 → err_overflow=1 and outstanding stays 8. Then resp id=3 → outstanding=7 and a request to slot 3 is accepted.
- Same-cycle collision: table full, req id=9 and resp id=0 in the same cycle → id 9 is dropped, err_overflow=1, outstanding=7. Separately, with the table empty, req id=4 and resp id=4 in the same cycle → err_unmatched=1 and outstanding=1.
- Duplicate and unmatched IDs: two reqs with id=2 at cycles 0 and 3; resp id=2 at cycle 10 → latency 10 from entry 0. A second resp id=2 at cycle 12 → latency 9. Resp id=77 → err_unmatched=1 with no stat_valid.
- Saturation and max: req at globalCycle=0, resp at globalCycle=0x1_0000_0005 → stat_latency=0xFFFFFFFF and max_latency=0xFFFFFFFF. A later latency of 3 leaves max_latency unchanged.
- Async reset: assert reset low between clock edges with 4 entries outstanding and a stat pulse pending → outputs clear immediately, with outstanding=0, stat_valid=0 and track_ready=1.
